// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// registers each fetched {pc, instr} pair into the IF/ID slot.
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] add_src1_o,
    output logic [63:0] add_src2_o,
    input  logic [63:0] add_sum_i,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [63:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        if_id_valid_o,
    output logic [63:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    input  logic        if_id_ready_i
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        slot_valid_q, slot_valid_d;
    logic [63:0] slot_pc_q, slot_pc_d;
    logic [31:0] slot_instr_q, slot_instr_d;
    logic        req_valid;
    logic        rsp_load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid_i) begin
            // An outstanding request still owes us a response; DROP swallows it.
            unique case (state_q)
                S_REQ:   state_d = S_REQ;
                S_WAIT:  state_d = imem_rsp_valid_i ? S_REQ : S_DROP;
                S_DROP:  state_d = imem_rsp_valid_i ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ:   if (req_valid && imem_req_ready_i) state_d = S_WAIT;
                S_WAIT:  if (imem_rsp_valid_i) state_d = S_REQ;
                S_DROP:  if (imem_rsp_valid_i) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_comb begin
        req_valid = rst_n && (state_q == S_REQ) && (!slot_valid_q || if_id_ready_i)
                    && !redirect_valid_i;
        rsp_load  = (state_q == S_WAIT) && imem_rsp_valid_i && !redirect_valid_i;
    end

    always_comb begin
        pc_d         = pc_q;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
        if (redirect_valid_i) begin
            pc_d         = {redirect_pc_i[63:2], 2'b00};
            slot_valid_d = 1'b0;
            slot_instr_d = NOP_INSTR;
        end else if (rsp_load) begin
            pc_d         = add_sum_i;
            slot_valid_d = 1'b1;
            slot_pc_d    = pc_q;
            slot_instr_d = imem_rsp_data_i;
        end else if (slot_valid_q && if_id_ready_i) begin
            slot_valid_d = 1'b0;
            slot_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= '0;
            slot_instr_q <= NOP_INSTR;
        end else begin
            pc_q         <= pc_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
        end
    end

    assign add_src1_o       = pc_q;
    assign add_src2_o       = 64'd4;
    assign imem_addr_o      = pc_q;
    assign imem_req_valid_o = req_valid;
    assign if_id_valid_o    = slot_valid_q;
    assign if_id_pc_o       = slot_pc_q;
    assign if_id_instr_o    = slot_instr_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected slot contents are queued by the
// driver and checked by a monitor each time decode consumes the slot.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] add_src1, add_src2, add_sum;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        req_valid, req_ready;
    logic [63:0] imem_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    int unsigned mem_lat = 1;
    int unsigned mem_cnt = 0;
    logic [63:0] mem_addr = '0;

    if_fetch_stage #(
        .RESET_PC (64'h0000_0000_0000_1000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .add_src1_o      (add_src1),
        .add_src2_o      (add_src2),
        .add_sum_i       (add_sum),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .imem_req_valid_o(req_valid),
        .imem_req_ready_i(req_ready),
        .imem_addr_o     (imem_addr),
        .imem_rsp_valid_i(rsp_valid),
        .imem_rsp_data_i (rsp_data),
        .if_id_valid_o   (id_valid),
        .if_id_pc_o      (id_pc),
        .if_id_instr_o   (id_instr),
        .if_id_ready_i   (id_ready)
    );

    // Shared ripple adder stand-in; 64-bit result wraps naturally.
    assign add_sum = add_src1 + add_src2;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return 32'hA000_0000 | {4'h0, a[27:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    // One clock: memory captures accepts at negedge, answers mem_lat cycles later.
    task automatic step();
        @(negedge clk);
        if (rst_n && req_valid && req_ready) begin
            mem_addr = imem_addr;
            mem_cnt  = mem_lat;
        end
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_data  = instr_of(mem_addr);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_slot_pc", id_pc, 64'hx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("slot_pc", id_pc, e.pc);
                check("slot_instr", {32'h0, id_instr}, {32'h0, e.instr});
            end
        end
    end

    initial begin
        #5000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        req_ready      = 1'b1;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        id_ready       = 1'b1;

        // Reset state
        step();
        step();
        #1;
        check("rst_req_valid", {63'h0, req_valid}, 64'h0);
        check("rst_id_valid", {63'h0, id_valid}, 64'h0);
        check("rst_id_pc", id_pc, 64'h0);
        check("rst_id_instr", {32'h0, id_instr}, 64'h13);

        // Sequential fetch and back-pressure
        push(64'h1000, 32'hA000_1000);
        push(64'h1004, 32'hA000_1004);
        push(64'h1008, 32'hA000_1008);
        rst_n = 1'b1;
        #1;
        check("c0_req_valid", {63'h0, req_valid}, 64'h1);
        check("c0_addr", imem_addr, 64'h1000);
        check("c0_nop_before_load", {32'h0, id_instr}, 64'h13);
        step();
        step();
        #1;
        check("c2_addr", imem_addr, 64'h1004);
        check("c2_req_valid", {63'h0, req_valid}, 64'h1);
        step();
        step();
        id_ready = 1'b0;
        #1;
        check("bp_req_valid", {63'h0, req_valid}, 64'h0);
        step();
        step();
        #1;
        check("bp_hold_valid", {63'h0, id_valid}, 64'h1);
        check("bp_hold_pc", id_pc, 64'h1004);
        check("bp_req_still_0", {63'h0, req_valid}, 64'h0);
        id_ready = 1'b1;
        #1;
        check("bp_release_req", {63'h0, req_valid}, 64'h1);
        check("bp_release_addr", imem_addr, 64'h1008);
        step();
        step();

        // Redirect in WAIT with no response: late response dropped
        mem_lat = 2;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2002;
        #1;
        check("rw_req_valid", {63'h0, req_valid}, 64'h0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("drop_req_valid", {63'h0, req_valid}, 64'h0);
        check("drop_pc", imem_addr, 64'h2000);
        check("drop_flushed", {63'h0, id_valid}, 64'h0);
        check("drop_rsp_present", {63'h0, rsp_valid}, 64'h1);
        mem_lat = 1;
        step();
        #1;
        check("after_drop_id_valid", {63'h0, id_valid}, 64'h0);
        check("after_drop_instr", {32'h0, id_instr}, 64'h13);
        check("after_drop_req", {63'h0, req_valid}, 64'h1);
        check("after_drop_addr", imem_addr, 64'h2000);
        push(64'h2000, 32'hA000_2000);
        step();
        step();

        // Redirect coincident with a response in WAIT
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        step();
        redirect_valid = 1'b0;
        #1;
        check("coinc_req_valid", {63'h0, req_valid}, 64'h1);
        check("coinc_addr", imem_addr, 64'h3000);
        check("coinc_id_valid", {63'h0, id_valid}, 64'h0);
        push(64'h3000, 32'hA000_3000);
        step();
        step();

        // Wrap-around of the PC
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        check("redir_cycle_no_req", {63'h0, req_valid}, 64'h0);
        step();
        redirect_valid = 1'b0;
        #1;
        check("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        push(64'hFFFF_FFFF_FFFF_FFFC, 32'hAFFF_FFFC);
        step();
        step();
        #1;
        check("wrap_addr1", imem_addr, 64'h0);

        // Reset in WAIT overrides response and redirect
        step();
        rst_n          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h5000;
        mem_cnt        = 0;
        step();
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
        req_ready      = 1'b0;
        rsp_valid      = 1'b1;
        rsp_data       = 32'hDEAD_BEEF;
        #1;
        check("rw_rst_id_valid", {63'h0, id_valid}, 64'h0);
        check("rw_rst_instr", {32'h0, id_instr}, 64'h13);
        check("rw_rst_pc", imem_addr, 64'h1000);
        check("rw_rst_req", {63'h0, req_valid}, 64'h1);
        step();
        #1;
        check("stray_rsp_id_valid", {63'h0, id_valid}, 64'h0);
        check("stray_rsp_instr", {32'h0, id_instr}, 64'h13);
        check("stray_rsp_addr", imem_addr, 64'h1000);

        // Reset with a valid slot held by back-pressure
        req_ready = 1'b1;
        step();
        step();
        id_ready = 1'b0;
        #1;
        check("held_valid", {63'h0, id_valid}, 64'h1);
        check("held_pc", id_pc, 64'h1000);
        check("held_instr", {32'h0, id_instr}, 64'hA000_1000);
        rst_n = 1'b0;
        step();
        #1;
        check("rst_slot_valid", {63'h0, id_valid}, 64'h0);
        check("rst_slot_instr", {32'h0, id_instr}, 64'h13);
        check("rst_slot_pc", id_pc, 64'h0);
        rst_n = 1'b1;

        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
